// File: rtl/instr_enc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : instr_enc_pkg
// Description : Shared formats, error-bit indices and immediate limits for the
//               RV32I instruction encoder.
// Revision    : 1.0
// ============================================================================
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam int ERR_RANGE = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_FMT   = 2;
    localparam int ERR_RTRIP = 3;

    localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_I_MAX =  32'sd2047;
    localparam logic signed [31:0] IMM_S_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_S_MAX =  32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX =  32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX =  32'sd1048574;

    localparam logic [31:0] NOP_ILLEGAL = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/instr_imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_imm_pack
// Description : Combinational packer of instruction fields into an RV32I word.
// Revision    : 1.0
// ============================================================================
module instr_imm_pack
    import instr_enc_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr
);

    always_comb begin
        o_instr = NOP_ILLEGAL;
        case (i_fmt)
            FMT_R: o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
            FMT_U: o_instr = {i_imm[31:12], i_rd, i_opcode};
            FMT_J: o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            default: o_instr = NOP_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Two-stage valid/ready RV32I instruction packer with format,
//               alignment and range checks plus saturating status counters.
//               Optional build macro: INSTR_ENC_ROUNDTRIP_CHECK_EN
// Revision    : 1.0
// ============================================================================
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [3:0]       out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    logic               r_s1_v;
    logic [2:0]         r_s1_fmt;
    logic [6:0]         r_s1_op;
    logic [4:0]         r_s1_rd;
    logic [2:0]         r_s1_f3;
    logic [4:0]         r_s1_rs1;
    logic [4:0]         r_s1_rs2;
    logic [6:0]         r_s1_f7;
    logic [31:0]        r_s1_imm;
    logic [2:0]         r_s1_err;
    logic               r_s2_v;
    logic [31:0]        r_out_instr;
    logic [3:0]         r_out_err;
    logic [CNT_W-1:0]   r_enc_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_s2_adv;
    logic               w_out_fire;
    logic signed [31:0] w_imm_s;
    logic               w_fmt_bad;
    logic               w_align;
    logic               w_range;
    logic [2:0]         w_err;
    logic [31:0]        w_packed;
    logic               w_rtrip;
    logic [3:0]         w_s2_err;

    assign w_s2_adv   = !r_s2_v || out_ready;
    assign in_ready   = !r_s1_v || w_s2_adv;
    assign w_out_fire = r_s2_v && out_ready;

    always_comb begin
        w_imm_s   = $signed(in_imm);
        w_fmt_bad = (in_fmt > FMT_J);
        w_align   = 1'b0;
        w_range   = 1'b0;
        case (in_fmt)
            FMT_I: w_range = (w_imm_s < IMM_I_MIN) || (w_imm_s > IMM_I_MAX);
            FMT_S: w_range = (w_imm_s < IMM_S_MIN) || (w_imm_s > IMM_S_MAX);
            FMT_B: begin
                w_align = in_imm[0];
                w_range = (w_imm_s < IMM_B_MIN) || (w_imm_s > IMM_B_MAX);
            end
            FMT_U: w_align = |in_imm[11:0];
            FMT_J: begin
                w_align = in_imm[0];
                w_range = (w_imm_s < IMM_J_MIN) || (w_imm_s > IMM_J_MAX);
            end
            default: ;
        endcase
        // Only the highest-priority flag survives.
        w_err = '0;
        if (w_fmt_bad)    w_err[ERR_FMT]   = 1'b1;
        else if (w_align) w_err[ERR_ALIGN] = 1'b1;
        else if (w_range) w_err[ERR_RANGE] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_fmt <= '0;
            r_s1_op  <= '0;
            r_s1_rd  <= '0;
            r_s1_f3  <= '0;
            r_s1_rs1 <= '0;
            r_s1_rs2 <= '0;
            r_s1_f7  <= '0;
            r_s1_imm <= '0;
            r_s1_err <= '0;
        end else if (in_ready) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_fmt <= in_fmt;
                r_s1_op  <= in_opcode;
                r_s1_rd  <= in_rd;
                r_s1_f3  <= in_funct3;
                r_s1_rs1 <= in_rs1;
                r_s1_rs2 <= in_rs2;
                r_s1_f7  <= in_funct7;
                r_s1_imm <= in_imm;
                r_s1_err <= w_err;
            end
        end
    end

    instr_imm_pack u_pack (
        .i_fmt    (r_s1_fmt),
        .i_opcode (r_s1_op),
        .i_rd     (r_s1_rd),
        .i_funct3 (r_s1_f3),
        .i_rs1    (r_s1_rs1),
        .i_rs2    (r_s1_rs2),
        .i_funct7 (r_s1_f7),
        .i_imm    (r_s1_imm),
        .o_instr  (w_packed)
    );

`ifdef INSTR_ENC_ROUNDTRIP_CHECK_EN
    logic [31:0] w_rt_imm;
    logic [31:0] w_rt_mask;

    // Re-extract the immediate the way the core decoder would.
    always_comb begin
        w_rt_imm  = '0;
        w_rt_mask = '0;
        case (r_s1_fmt)
            FMT_I: begin
                w_rt_imm  = {{20{w_packed[31]}}, w_packed[31:20]};
                w_rt_mask = 32'h0000_0FFF;
            end
            FMT_S: begin
                w_rt_imm  = {{20{w_packed[31]}}, w_packed[31:25], w_packed[11:7]};
                w_rt_mask = 32'h0000_0FFF;
            end
            FMT_B: begin
                w_rt_imm  = {{19{w_packed[31]}}, w_packed[31], w_packed[7],
                             w_packed[30:25], w_packed[11:8], 1'b0};
                w_rt_mask = 32'h0000_1FFE;
            end
            FMT_U: begin
                w_rt_imm  = {w_packed[31:12], 12'h000};
                w_rt_mask = 32'hFFFF_F000;
            end
            FMT_J: begin
                w_rt_imm  = {{11{w_packed[31]}}, w_packed[31], w_packed[19:12],
                             w_packed[20], w_packed[30:21], 1'b0};
                w_rt_mask = 32'h001F_FFFE;
            end
            default: ;
        endcase
    end

    assign w_rtrip = |((w_rt_imm ^ r_s1_imm) & w_rt_mask);
`else
    assign w_rtrip = 1'b0;
`endif

    always_comb begin
        w_s2_err = '0;
        if (|r_s1_err) w_s2_err[2:0]     = r_s1_err;
        else           w_s2_err[ERR_RTRIP] = w_rtrip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v      <= 1'b0;
            r_out_instr <= NOP_ILLEGAL;
            r_out_err   <= '0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_instr <= (|r_s1_err) ? NOP_ILLEGAL : w_packed;
                r_out_err   <= w_s2_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_out_fire) begin
            if (|r_out_err) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end else begin
                if (r_enc_cnt != '1) r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign enc_count = r_enc_cnt;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: directed vector table,
//               stall/reset sequences and randomized traffic vs. a reference model.
// Revision    : 1.0
// ============================================================================
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [3:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_err;
    logic        cnt_clr;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int   n_pass;
    int   n_total;
    int   exp_enc;
    int   exp_err;
    exp_t exp_q[$];
    vec_t vecs[20];
    int   bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097,
                      1048574, 1048575, 1048576, -1048576, -1048578};

    instr_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_funct3 (in_funct3),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_clr   (cnt_clr),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Encoding rules written as field arithmetic on the signed immediate value.
    function automatic exp_t model(input logic [2:0] fmt, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [6:0] f7, input logic [31:0] imm);
        exp_t    r;
        longint  v;
        longint  lo;
        longint  hi;
        bit      has_rng;
        bit      mis;
        bit [31:0] u;
        v = longint'($signed(imm));
        u = imm;
        has_rng = 0; mis = 0; lo = 0; hi = 0;
        case (fmt)
            3'd1, 3'd2: begin has_rng = 1; lo = -2048; hi = 2047; end
            3'd3: begin has_rng = 1; lo = -4096; hi = 4094; mis = (v % 2) != 0; end
            3'd4: mis = (u % 4096) != 0;
            3'd5: begin has_rng = 1; lo = -1048576; hi = 1048574; mis = (v % 2) != 0; end
            default: ;
        endcase
        r.err = 4'd0;
        if (fmt > 3'd5)                         r.err = 4'd4;
        else if (mis)                           r.err = 4'd2;
        else if (has_rng && (v < lo || v > hi)) r.err = 4'd1;
        r.instr = 32'(op);
        case (fmt)
            3'd0: r.instr += (32'(f7) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15)
                           + (32'(f3) << 12) + (32'(rd) << 7);
            3'd1: r.instr += ((u % 4096) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
                           + (32'(rd) << 7);
            3'd2: r.instr += (((u / 32) % 128) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15)
                           + (32'(f3) << 12) + ((u % 32) << 7);
            3'd3: r.instr += (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25)
                           + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
                           + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7);
            3'd4: r.instr += (u - (u % 4096)) + (32'(rd) << 7);
            3'd5: r.instr += (((u / 1048576) % 2) << 31) + (((u / 2) % 1024) << 21)
                           + (((u / 2048) % 2) << 20) + (((u / 4096) % 256) << 12)
                           + (32'(rd) << 7);
            default: ;
        endcase
        if (r.err != 4'd0) r.instr = 32'h0;
        return r;
    endfunction

    task automatic set_fields(input vec_t v);
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_funct3 = v.f3;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    task automatic rand_fields();
        in_fmt    = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
        in_opcode = 7'($urandom);
        in_rd     = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct7 = 7'($urandom);
        case ($urandom_range(0, 4))
            0: in_imm = $urandom;
            1: in_imm = 32'(int'($urandom_range(0, 8400)) - 4200);
            2: in_imm = 32'(bnd[$urandom_range(0, 13)]);
            3: in_imm = $urandom & 32'hFFFF_F000;
            default: in_imm = 32'(int'($urandom_range(0, 4194304)) - 2097152);
        endcase
    endtask

    // One clock: entered at a falling edge with inputs driven, returns at the next.
    task automatic tick(output bit acc);
        exp_t e;
        #1;
        check("enc_count", 32'(enc_count), 32'(exp_enc));
        check("err_count", 32'(err_count), 32'(exp_err));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL out_unexpected: got word %h with no request pending", out_instr);
            end else begin
                check("out_instr", out_instr, exp_q[0].instr);
                check("out_err", 32'(out_err), 32'(exp_q[0].err));
            end
        end
        acc = in_valid && in_ready;
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.err != 4'd0) exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
            else               exp_enc = (exp_enc < 65535) ? exp_enc + 1 : exp_enc;
        end
        if (cnt_clr) begin
            exp_enc = 0;
            exp_err = 0;
        end
        if (acc) exp_q.push_back(model(in_fmt, in_opcode, in_rd, in_funct3,
                                       in_rs1, in_rs2, in_funct7, in_imm));
        @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        set_fields(v);
        in_valid = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
        #1;
        check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check($sformatf("vec%0d_lat1_valid", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d_instr", idx), out_instr, v.exp_instr);
        check($sformatf("vec%0d_err", idx), 32'(out_err), 32'(v.exp_err));
        if (v.exp_err != 4'd0) exp_err++;
        else                   exp_enc++;
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_enc_count", idx), 32'(enc_count), 32'(exp_enc));
        check($sformatf("vec%0d_err_count", idx), 32'(err_count), 32'(exp_err));
        check($sformatf("vec%0d_drained", idx), 32'(out_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int k;
        int base;
        n_pass = 0; n_total = 0; exp_enc = 0; exp_err = 0;

        //            fmt   op      rd    f3    rs1   rs2   f7     imm            instr          err
        vecs[0]  = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 4'd0};
        vecs[1]  = '{3'd2, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 7'h00, 32'h00000008, 32'h0021A423, 4'd0};
        vecs[2]  = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 4'd0};
        vecs[3]  = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000003, 32'h00000000, 4'd2};
        vecs[4]  = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000800, 32'h001000EF, 4'd0};
        vecs[5]  = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00100000, 32'h00000000, 4'd1};
        vecs[6]  = '{3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 32'h00000000, 4'd4};
        vecs[7]  = '{3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000003, 32'h00000000, 4'd4};
        vecs[8]  = '{3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h000007FF, 32'h7FF00013, 4'd0};
        vecs[9]  = '{3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFF800, 32'h80000013, 4'd0};
        vecs[10] = '{3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000800, 32'h00000000, 4'd1};
        vecs[11] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 4'd0};
        vecs[12] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00001000, 32'h00000000, 4'd1};
        vecs[13] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000FFF, 32'h00000000, 4'd2};
        vecs[14] = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 32'h123452B7, 4'd0};
        vecs[15] = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345001, 32'h00000000, 4'd2};
        vecs[16] = '{3'd0, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'hDEADBEEF, 32'h403100B3, 4'd0};
        vecs[17] = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFF00000, 32'h800000EF, 4'd0};
        vecs[18] = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFEFFFFE, 32'h00000000, 4'd1};
        vecs[19] = '{3'd2, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 7'h00, 32'hFFFFF7FF, 32'h00000000, 4'd1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        set_fields(vecs[0]);
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Three back-to-back requests against a four-cycle output stall.
        k = 0; base = exp_enc; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (k < 3);
            set_fields(vecs[(k < 3) ? k : 2]);
            #1;
            check($sformatf("stall%0d_in_ready", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
            tick(acc);
            if (acc) k++;
        end
        check("stall_accepted", 32'(k), 32'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = (k < 3);
            set_fields(vecs[(k < 3) ? k : 2]);
            #1;
            check($sformatf("stall_drain%0d_valid", c), 32'(out_valid), 32'd1);
            tick(acc);
            if (acc) k++;
        end
        in_valid = 1'b0;
        #1;
        check("stall_drain_empty", 32'(out_valid), 32'd0);
        check("stall_enc_count", 32'(enc_count), 32'(base + 3));
        tick(acc);

        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            cnt_clr   = ($urandom_range(0, 99) < 3);
            rand_fields();
            tick(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick(acc);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
        end
        tick(acc);

        // Reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1;
        set_fields(vecs[0]);
        tick(acc);
        set_fields(vecs[1]);
        tick(acc);
        if (exp_enc == 0) exp_enc = exp_enc;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_instr", out_instr, 32'd0);
        check("midrst_enc_count", 32'(enc_count), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        exp_q.delete();
        exp_enc = 0; exp_err = 0;
        @(negedge clk);
        #1;
        check("midrst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("postrst_idle%0d", c), 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        apply_vec(vecs[4], 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
